multi_instr_receiver: RTL and testbench
=======================================

# multi_instr_receiver

Parametrised instruction-sequence receiver sitting between the host-side instruction sources (application, maintenance, and any further agents) and the dispatcher's instruction FIFO bank. It arbitrates among NUM_SRC sources and locks onto one source for a whole sequence, up to and including its END_ISEQ instruction. It stripes the accepted instructions round-robin across NUM_FIFO output FIFOs, and pulses `process_iseq` when the sequence completes. It adds selectable arbitration, per-source END forwarding, and a sequence-length guard.

## Interface
- NUM_SRC, 2: number of instruction sources; index 0 is highest priority in fixed mode.
- NUM_FIFO, 2: number of dispatcher instruction FIFOs; must be ≥1.
- INSTR_W, 32: instruction width; the opcode is bits [INSTR_W-1:INSTR_W-4].
- ARB_RR, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- FWD_END_MASK, {NUM_SRC{1'b1}}: bit s=1 means source s's END_ISEQ is written to a FIFO; 0 means it is consumed silently.
- MAX_LEN, 1024: maximum instructions per sequence, counting END; must be ≥2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dispatcher_ready  in  1  dispatcher can accept a new sequence.
- src_en  in  NUM_SRC  per-source instruction valid.
- src_instr  in  NUM_SRC*INSTR_W  per-source instruction; source s occupies slice [s*INSTR_W +: INSTR_W].
- src_ack  out  NUM_SRC  combinational; one-hot or zero.
- fifo_en  out  NUM_FIFO  registered write strobes; one-hot or zero.
- fifo_data  out  INSTR_W  registered data, shared by all FIFOs.
- process_iseq  out  1  registered one-cycle pulse at sequence completion.
- active_src  out  max(1,clog2(NUM_SRC))  registered index of the granted source.
- seq_len  out  clog2(MAX_LEN+1)  registered count of instructions accepted in the current sequence.
- len_err  out  1  registered; set on a forced termination and held until the next grant.

## Operation
- States: IDLE, BUSY.
- IDLE, grant condition: dispatcher_ready & ~process_iseq & (|src_en).
- IDLE, grant actions:
  - Choose g according to the arbitration mode.
  - Assert src_ack[g] in the same cycle.
  - Capture src_instr[g] as the first accepted instruction.
  - Set active_src=g, seq_len=1, clear len_err, go to BUSY.
- Round-robin pointer: records the last granted index. The search starts at pointer+1 and wraps from NUM_SRC-1 to 0. The pointer updates only on a grant.
- BUSY:
  - src_ack[active_src] stays high every cycle.
  - Each cycle with src_en[active_src]=1 accepts one instruction and increments seq_len.
  - src_en low means no accept, no write, and the block stays in BUSY.
  - Other sources are never acknowledged.
- END detection: an accepted instruction whose opcode equals END_ISEQ terminates the sequence. This applies in both BUSY and the grant cycle.
- END handling:
  - The END is written only if FWD_END_MASK[active_src]=1.
  - process_iseq pulses on the next cycle.
  - The state returns to IDLE.
- Length guard: if the MAX_LEN-th accepted instruction is not END, that instruction is still written.
- Forced termination: the sequence is terminated exactly as for END, i.e. process_iseq pulses and the state returns to IDLE. In addition, len_err is set.
- FIFO striping:
  - Counter sel ranges 0..NUM_FIFO-1.
  - fifo_en[k] = write_r & (sel==k).
  - sel increments after every registered write and wraps from NUM_FIFO-1 to 0.
  - sel resets to 0 in the cycle following a process_iseq pulse, so every sequence starts at FIFO 0.
- Reset values: state IDLE; fifo_en, fifo_data, process_iseq, active_src, seq_len, len_err, sel and the RR pointer all 0. src_ack is 0 during reset.

## Timing
- src_ack is combinational from state, src_en and dispatcher_ready, with no register stage.
- Accept-to-write latency is 1 cycle: an instruction accepted in cycle t appears on fifo_en/fifo_data in cycle t+1.
- END accepted in cycle t:
  - The END write (if forwarded) and process_iseq both occur in cycle t+1.
  - The earliest next grant is cycle t+2.
- Maximum throughput is one instruction per cycle with no bubbles inside a sequence.
- Single-cycle sequence: a grant-cycle END gives process_iseq one cycle after the grant, and seq_len reads 1.
- dispatcher_ready dropping while in BUSY has no effect on the sequence in progress.
- Asynchronous reset mid-sequence clears immediately. Partially written sequences are not rolled back; the dispatcher FIFOs are reset by the same rst_n.

## Structure
- Shared constants stay in softMC.inc:
  - END_ISEQ opcode value.
  - Opcode field position.
  - A clog2 helper function, used for active_src and seq_len widths.
- One sub-module, `rr_arbiter`: NUM_SRC-wide request in, one-hot grant out, a grant-enable input that updates the pointer, and a fixed-priority bypass selected by ARB_RR.
- Everything else (FSM, length counter, striping counter, output registers) is inline.

## Test plan
- NUM_SRC=2, NUM_FIFO=2, src0 sends A,B,C,END:
  - Writes: A→FIFO0, B→FIFO1, C→FIFO0, END→FIFO1.
  - process_iseq coincides with the END write; seq_len=4.
- FWD_END_MASK=2'b01, src1 sends X,END: X→FIFO0, END not written, process_iseq pulses, next sequence starts at FIFO0.
- ARB_RR=1, NUM_SRC=4, all src_en held high, each source sending END immediately:
  - Grant order 0,1,2,3,0.
  - Fixed mode under the same stimulus grants 0 every time.
- MAX_LEN=4, src0 sends 6 non-END instructions:
  - 4 are written; process_iseq and len_err=1 follow the 4th.
  - The next grant goes to src0 again and clears len_err.
- NUM_FIFO=3, a 7-instruction sequence: FIFO order 0,1,2,0,1,2,0.
- src_en gaps mid-sequence hold BUSY with no writes.
- rst_n asserted mid-sequence: all outputs are 0 immediately; the first grant after release goes to the highest-priority requester.

Source files
------------

// File: rtl/multi_instr_receiver_pkg.sv
// Shared constants for the instruction-sequence receiver: the END_ISEQ opcode,
// the opcode field geometry, the FSM state type and a clog2 helper.
package multi_instr_receiver_pkg;

  localparam int          OPCODE_W = 4;
  localparam logic [3:0]  END_ISEQ = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Ceiling log2 for positive values; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_instr_receiver_arbiter.sv
// Request arbiter: one-hot grant among N requesters, either fixed priority
// (lowest index wins) or round-robin starting after the last granted index.
module rr_arbiter
  import multi_instr_receiver_pkg::*;
#(
  parameter int N  = 2,
  parameter bit RR = 1'b0,
  localparam int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          gnt_en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  // Until the first grant there is no "last granted" index, so the search
  // starts at 0 rather than ptr+1; this keeps index 0 first after reset.
  logic          primed;
  logic          found;
  int            start;
  int            idx;

  // Scan requesters from the start index, wrapping, and grant the first one.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    start   = 0;
    idx     = 0;
    if (RR && primed) start = (int'(ptr) + 1) % N;
    for (int i = 0; i < N; i++) begin
      idx = (start + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = IW'(idx);
      end
    end
  end

  // Remember the last granted index; only moves when a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      primed <= 1'b0;
    end else if (gnt_en && found) begin
      ptr    <= gnt_idx;
      primed <= 1'b1;
    end
  end

endmodule

// File: rtl/multi_instr_receiver.sv
// Instruction-sequence receiver: locks onto one source for a whole sequence
// (through END_ISEQ or the length limit), stripes accepted instructions
// round-robin over the dispatcher FIFOs and pulses process_iseq at the end.
//
// Handshake: src_ack is the ready for src_en. An instruction is accepted in a
// cycle where src_en[s] and src_ack[s] are both high. In IDLE the ack is the
// grant (combinational); in BUSY the owner's ack stays high every cycle and a
// low src_en simply means no transfer that cycle.
module multi_instr_receiver
  import multi_instr_receiver_pkg::*;
#(
  parameter int                NUM_SRC      = 2,
  parameter int                NUM_FIFO     = 2,
  parameter int                INSTR_W      = 32,
  parameter bit                ARB_RR       = 1'b0,
  parameter logic [NUM_SRC-1:0] FWD_END_MASK = {NUM_SRC{1'b1}},
  parameter int                MAX_LEN      = 1024,
  localparam int SRC_W  = (NUM_SRC > 1) ? clog2(NUM_SRC) : 1,
  localparam int LEN_W  = clog2(MAX_LEN + 1),
  localparam int FSEL_W = (NUM_FIFO > 1) ? clog2(NUM_FIFO) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dispatcher_ready,
  input  logic [NUM_SRC-1:0]         src_en,
  input  logic [NUM_SRC*INSTR_W-1:0] src_instr,
  output logic [NUM_SRC-1:0]         src_ack,
  output logic [NUM_FIFO-1:0]        fifo_en,
  output logic [INSTR_W-1:0]         fifo_data,
  output logic                       process_iseq,
  output logic [SRC_W-1:0]           active_src,
  output logic [LEN_W-1:0]           seq_len,
  output logic                       len_err
);

  state_t               state;
  logic [FSEL_W-1:0]    sel;
  logic [NUM_SRC-1:0]   arb_gnt;
  logic [SRC_W-1:0]     arb_idx;
  logic                 grant;
  logic                 accept;
  logic [SRC_W-1:0]     cur_src;
  logic [INSTR_W-1:0]   acc_instr;
  logic                 is_end;
  logic [LEN_W-1:0]     new_len;
  logic                 term;
  logic                 do_write;

  // rst_n gates the grant so no ack escapes while reset is held.
  assign grant = rst_n && (state == ST_IDLE) && dispatcher_ready &&
                 !process_iseq && (|src_en);

  rr_arbiter #(
    .N  (NUM_SRC),
    .RR (ARB_RR)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (src_en),
    .gnt_en  (grant),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Accept path: which source is transferring this cycle and what it sent.
  always_comb begin
    cur_src   = grant ? arb_idx : active_src;
    accept    = grant || ((state == ST_BUSY) && src_en[active_src]);
    acc_instr = src_instr[cur_src*INSTR_W +: INSTR_W];
    is_end    = (acc_instr[INSTR_W-1 -: OPCODE_W] == END_ISEQ);
    new_len   = grant ? LEN_W'(1) : seq_len + 1'b1;
    term      = accept && (is_end || (new_len == LEN_W'(MAX_LEN)));
    do_write  = accept && (!is_end || FWD_END_MASK[cur_src]);
  end

  // Ack: owner held high while BUSY, otherwise the arbiter grant.
  always_comb begin
    src_ack = '0;
    if (state == ST_BUSY) src_ack[active_src] = 1'b1;
    else if (grant)       src_ack = arb_gnt;
  end

  // Sequence FSM with registered FIFO strobes, status and striping counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sel          <= '0;
      fifo_en      <= '0;
      fifo_data    <= '0;
      process_iseq <= 1'b0;
      active_src   <= '0;
      seq_len      <= '0;
      len_err      <= 1'b0;
    end else begin
      fifo_en      <= '0;
      process_iseq <= term;
      if (do_write) begin
        fifo_en   <= NUM_FIFO'(1) << sel;
        fifo_data <= acc_instr;
        sel       <= (sel == FSEL_W'(NUM_FIFO - 1)) ? '0 : sel + 1'b1;
      end
      // Every sequence begins at FIFO 0.
      if (term) sel <= '0;
      if (grant) begin
        active_src <= arb_idx;
        len_err    <= 1'b0;
      end
      if (accept) seq_len <= new_len;
      if (term && !is_end) len_err <= 1'b1;
      case (state)
        ST_IDLE: if (grant && !term) state <= ST_BUSY;
        ST_BUSY: if (term)           state <= ST_IDLE;
        default:                     state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_instr_receiver.sv
// Bench for multi_instr_receiver: a fixed-priority and a round-robin instance
// share the same stimulus; each is checked every cycle against a sequence-level
// model, with directed scenarios pinning literal expectations.
module tb_multi_instr_receiver;

  localparam int         NS   = 4;
  localparam int         NF   = 3;
  localparam int         W    = 16;
  localparam int         ML   = 5;
  localparam logic [3:0] MASK = 4'b1101;
  localparam logic [3:0] ENDOP = 4'hF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dispatcher_ready = 1'b0;
  logic [NS-1:0]   src_en = '0;
  logic [NS*W-1:0] src_instr = '0;

  logic [NS-1:0] d_ack [2];
  logic [NF-1:0] d_fen [2];
  logic [W-1:0]  d_data [2];
  logic          d_pulse [2];
  logic [1:0]    d_src [2];
  logic [2:0]    d_len [2];
  logic          d_err [2];

  int n_checks = 0;
  int n_err    = 0;

  // Model state per instance (0 = fixed, 1 = round-robin).
  bit            m_busy [2];
  int            m_owner [2];
  int            m_last [2];
  int            m_len [2];
  int            m_wc [2];
  logic [NF-1:0] e_fen [2];
  logic [W-1:0]  e_data [2];
  logic          e_pulse [2];
  logic          e_err [2];
  logic [NS-1:0] fwd_mask;

  always #5 clk = ~clk;

  multi_instr_receiver #(
    .NUM_SRC(NS), .NUM_FIFO(NF), .INSTR_W(W), .ARB_RR(1'b0),
    .FWD_END_MASK(MASK), .MAX_LEN(ML)
  ) u_fx (
    .clk(clk), .rst_n(rst_n), .dispatcher_ready(dispatcher_ready),
    .src_en(src_en), .src_instr(src_instr), .src_ack(d_ack[0]),
    .fifo_en(d_fen[0]), .fifo_data(d_data[0]), .process_iseq(d_pulse[0]),
    .active_src(d_src[0]), .seq_len(d_len[0]), .len_err(d_err[0])
  );

  multi_instr_receiver #(
    .NUM_SRC(NS), .NUM_FIFO(NF), .INSTR_W(W), .ARB_RR(1'b1),
    .FWD_END_MASK(MASK), .MAX_LEN(ML)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .dispatcher_ready(dispatcher_ready),
    .src_en(src_en), .src_instr(src_instr), .src_ack(d_ack[1]),
    .fifo_en(d_fen[1]), .fifo_data(d_data[1]), .process_iseq(d_pulse[1]),
    .active_src(d_src[1]), .seq_len(d_len[1]), .len_err(d_err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [NS*W-1:0] put(input int s, input logic [W-1:0] v);
    logic [NS*W-1:0] r;
    r = '0;
    r[s*W +: W] = v;
    return r;
  endfunction

  // Arbitration rule: fixed = lowest index; RR = first requester after last grant.
  function automatic int pick(input int k, input logic [NS-1:0] en);
    int start;
    start = (k == 1 && m_last[k] >= 0) ? (m_last[k] + 1) % NS : 0;
    for (int i = 0; i < NS; i++) begin
      int idx;
      idx = (start + i) % NS;
      if (en[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_last[k] = -1; m_len[k] = 0; m_wc[k] = 0;
      e_fen[k] = '0; e_data[k] = '0; e_pulse[k] = 1'b0; e_err[k] = 1'b0;
    end
  endtask

  // Predict the ack for the current inputs and the registered outputs that follow.
  task automatic model_cycle(input int k);
    logic [NS-1:0] xa;
    logic [W-1:0]  ins;
    bit            acc;
    bit            endf;
    int            g;
    xa  = '0;
    acc = 0;
    if (m_busy[k]) begin
      xa[m_owner[k]] = 1'b1;
      acc = src_en[m_owner[k]];
    end else if (dispatcher_ready && !e_pulse[k] && src_en != '0) begin
      g = pick(k, src_en);
      xa[g] = 1'b1;
      acc = 1;
      m_owner[k] = g; m_busy[k] = 1; m_len[k] = 0; m_wc[k] = 0; m_last[k] = g;
      e_err[k] = 1'b0;
    end
    chk($sformatf("src_ack[%0d]", k), 32'(d_ack[k]), 32'(xa));
    e_fen[k]   = '0;
    e_pulse[k] = 1'b0;
    if (acc) begin
      ins  = src_instr[m_owner[k]*W +: W];
      m_len[k]++;
      endf = (ins[W-1 -: 4] == ENDOP);
      if (!endf || fwd_mask[m_owner[k]]) begin
        e_fen[k]  = NF'(1) << (m_wc[k] % NF);
        e_data[k] = ins;
        m_wc[k]++;
      end
      if (endf || m_len[k] == ML) begin
        e_pulse[k] = 1'b1;
        m_busy[k]  = 0;
        if (!endf) e_err[k] = 1'b1;
      end
    end
  endtask

  task automatic check_regs(input int k);
    chk($sformatf("fifo_en[%0d]", k), 32'(d_fen[k]), 32'(e_fen[k]));
    if (e_fen[k] != '0) chk($sformatf("fifo_data[%0d]", k), 32'(d_data[k]), 32'(e_data[k]));
    chk($sformatf("process_iseq[%0d]", k), 32'(d_pulse[k]), 32'(e_pulse[k]));
    chk($sformatf("active_src[%0d]", k), 32'(d_src[k]), 32'(m_owner[k]));
    chk($sformatf("seq_len[%0d]", k), 32'(d_len[k]), 32'(m_len[k]));
    chk($sformatf("len_err[%0d]", k), 32'(d_err[k]), 32'(e_err[k]));
  endtask

  // One clock: drive at posedge+1, check ack, step model, check registers.
  task automatic step(input logic [NS-1:0] en, input logic [NS*W-1:0] ins, input logic rdy);
    src_en = en; src_instr = ins; dispatcher_ready = rdy;
    #1;
    for (int k = 0; k < 2; k++) model_cycle(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_regs(k);
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic do_reset(input logic [NS-1:0] en);
    src_en = en; src_instr = {NS{16'h1234}}; dispatcher_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack",   32'(d_ack[k]),   0);
      chk("rst_fen",   32'(d_fen[k]),   0);
      chk("rst_data",  32'(d_data[k]),  0);
      chk("rst_pulse", 32'(d_pulse[k]), 0);
      chk("rst_src",   32'(d_src[k]),   0);
      chk("rst_len",   32'(d_len[k]),   0);
      chk("rst_err",   32'(d_err[k]),   0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [W-1:0] wa, wb, wc, we0, we1;
  logic [NS-1:0] ren;
  logic [NS*W-1:0] rins;
  logic [3:0] rop;
  int rr_exp [5];

  initial begin
    fwd_mask = MASK;
    wa = 16'h1AAA; wb = 16'h2BBB; wc = 16'h3CCC; we0 = 16'hF000; we1 = 16'hF111;
    rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 2; rr_exp[3] = 3; rr_exp[4] = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset('0);

    // A,B,C,END from source 0: FIFO 0,1,2 then END on FIFO 0 with the pulse.
    step(4'b0001, put(0, wa), 1'b1);
    chk("seq1_a_fen", 32'(d_fen[0]), 32'h1);
    step(4'b0001, put(0, wb), 1'b1);
    step(4'b0001, put(0, wc), 1'b1);
    chk("seq1_c_fen", 32'(d_fen[0]), 32'h4);
    step(4'b0001, put(0, we0), 1'b1);
    chk("seq1_end_fen",   32'(d_fen[0]),   32'h1);
    chk("seq1_end_pulse", 32'(d_pulse[0]), 32'h1);
    chk("seq1_end_len",   32'(d_len[0]),   32'h4);
    chk("seq1_end_data",  32'(d_data[0]),  32'hF000);
    step('0, '0, 1'b1);

    // Source 1 END is consumed silently; next sequence restarts at FIFO 0.
    step(4'b0010, put(1, 16'h4123), 1'b1);
    chk("seq2_x_fen", 32'(d_fen[1]), 32'h1);
    chk("seq2_src",   32'(d_src[1]), 32'h1);
    step(4'b0010, put(1, we1), 1'b1);
    chk("seq2_end_fen",   32'(d_fen[0]),   32'h0);
    chk("seq2_end_pulse", 32'(d_pulse[0]), 32'h1);
    step('0, '0, 1'b1);
    step(4'b0001, put(0, wa), 1'b1);
    chk("seq3_restart_fen", 32'(d_fen[0]), 32'h1);

    // src_en gap inside a sequence: ack held, no write, length unchanged.
    step(4'b0000, put(0, wb), 1'b1);
    chk("gap_fen", 32'(d_fen[0]), 32'h0);
    chk("gap_len", 32'(d_len[0]), 32'h1);
    chk("gap_ack", 32'(d_ack[0]), 32'h1);
    step(4'b0001, put(0, wb), 1'b0);
    chk("gap_b_fen", 32'(d_fen[0]), 32'h2);
    step(4'b0001, put(0, we0), 1'b1);
    step('0, '0, 1'b1);

    // Length guard: the 5th non-END is written and forces termination.
    for (int i = 1; i <= 6; i++) begin
      step(4'b0001, put(0, 16'h5000 + 16'(i)), 1'b1);
      if (i == 5) begin
        chk("len_guard_pulse", 32'(d_pulse[0]), 32'h1);
        chk("len_guard_err",   32'(d_err[0]),   32'h1);
        chk("len_guard_len",   32'(d_len[0]),   32'h5);
        chk("len_guard_fen",   32'(d_fen[0]),   32'h2);
      end
      if (i == 6) chk("len_guard_noack", 32'(d_fen[0]), 32'h0);
    end
    step(4'b0001, put(0, wa), 1'b1);
    chk("len_guard_regrant_err", 32'(d_err[0]), 32'h0);
    chk("len_guard_regrant_src", 32'(d_src[0]), 32'h0);
    step(4'b0001, put(0, we0), 1'b1);
    step('0, '0, 1'b1);

    // All sources requesting with immediate END: RR rotates, fixed stays at 0.
    do_reset('0);
    for (int j = 0; j < 10; j++) begin
      step(4'b1111, {NS{we0}}, 1'b1);
      if (j % 2 == 0) begin
        chk("rr_order",  32'(d_src[1]), 32'(rr_exp[j/2]));
        chk("fx_order",  32'(d_src[0]), 32'h0);
        chk("rr_single_len", 32'(d_len[1]), 32'h1);
      end
    end

    // Reset mid-sequence, then highest-priority requester wins.
    step(4'b0100, put(2, wa), 1'b1);
    step(4'b0100, put(2, wb), 1'b1);
    do_reset(4'b1111);
    step(4'b0110, put(1, wa) | put(2, wb), 1'b1);
    chk("post_rst_fx_src", 32'(d_src[0]), 32'h1);
    chk("post_rst_rr_src", 32'(d_src[1]), 32'h1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset(4'($urandom_range(0, 15)));
      ren = 4'($urandom_range(0, 15));
      for (int s = 0; s < NS; s++) begin
        rop = ($urandom_range(0, 3) == 0) ? ENDOP : 4'($urandom_range(0, 14));
        rins[s*W +: W] = {rop, 12'($urandom_range(0, 4095))};
      end
      step(ren, rins, ($urandom_range(0, 7) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
